// File: rtl/risc_pkg.sv
// Shared definitions for the VeriRISC core: opcodes, ALU operation codes,
// the controller phase enumeration and small decode helpers.
package risc_pkg;

    // Instruction opcodes (3-bit field of the instruction register)
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // ALU operation select codes, shared with the alu block
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    // The eight phases of one fetch/execute cycle
    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    // Instructions whose result goes through the accumulator load path
    function automatic logic is_alu_instr(input logic [2:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
    endfunction

    // Opcode to ALU operation; anything that is not a logic/arith op adds
    function automatic logic [2:0] alu_op_of(input logic [2:0] opcode);
        case (opcode)
            OP_AND:  return ALU_AND;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/risc_ctrl_if.sv
// Control bundle between the sequencing controller and the datapath
// (instruction register, PC, memory, accumulator, ALU).
interface risc_ctrl_if;

    logic [2:0] opcode;   // IR opcode field
    logic       zero;     // ALU zero flag
    logic       sel;      // memory address mux: 1 = PC, 0 = IR operand
    logic       rd;       // memory read enable
    logic       ld_ir;    // instruction register load
    logic       inc_pc;   // PC increment
    logic       ld_pc;    // PC load from IR operand
    logic       ld_ac;    // accumulator load
    logic       acc_src;  // accumulator source: 1 = memory data, 0 = ALU
    logic       wr;       // memory write enable
    logic       data_e;   // accumulator drives the data bus
    logic [2:0] alu_op;   // ALU operation select
    logic       halt;     // processor halted
    logic [2:0] phase;    // current phase, debug visibility

    // Controller side
    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, acc_src,
               wr, data_e, alu_op, halt, phase
    );

    // Datapath side
    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, acc_src,
               wr, data_e, alu_op, halt, phase
    );

endinterface

// File: rtl/risc_ctrl.sv
// VeriRISC instruction-sequencing controller: an 8-phase counter plus a
// halted flag, with every datapath strobe decoded combinationally from
// the phase, the opcode and the ALU zero flag.
module risc_ctrl
    import risc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    risc_ctrl_if.master bus
);

    // The datapath width does not shape any port of this block; it is only
    // sanity-checked so a bad parameterisation is caught at elaboration.
    if (WIDTH < 1) begin : g_width_chk
        $error("risc_ctrl: WIDTH must be at least 1");
    end

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;

    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, acc_src, wr, data_e, halt;
    logic [2:0] alu_op;
    logic       alu_instr;

    assign alu_instr = is_alu_instr(bus.opcode);

    // Phase counter and halted flag; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every flop sampling the values
        // from before this edge, regardless of statement order.
        if (rst) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next-phase logic and strobe decode for the current phase
    always_comb begin
        // NOTE: every output gets a default before the case below so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        phase_d  = phase_q;
        halted_d = halted_q;
        sel      = 1'b0;
        rd       = 1'b0;
        ld_ir    = 1'b0;
        inc_pc   = 1'b0;
        ld_pc    = 1'b0;
        ld_ac    = 1'b0;
        acc_src  = 1'b0;
        wr       = 1'b0;
        data_e   = 1'b0;
        halt     = 1'b0;
        // Driven in every phase so the ALU result settles before ld_ac
        alu_op   = alu_op_of(bus.opcode);

        if (halted_q) begin
            // Frozen in OP_ADDR with every strobe quiet until reset
            halt = 1'b1;
        end else begin
            phase_d = phase_e'(phase_q + 3'd1);
            acc_src = (bus.opcode == OP_LDA);
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    if (bus.opcode == OP_HLT) begin
                        // Stop here: no PC step, and stay parked in this phase
                        halted_d = 1'b1;
                        phase_d  = phase_q;
                    end else begin
                        inc_pc = 1'b1;
                    end
                end
                PH_OP_FETCH: begin
                    rd = alu_instr;
                end
                PH_ALU_OP: begin
                    rd     = alu_instr;
                    // The only phase where zero is looked at
                    inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
                    ld_pc  = (bus.opcode == OP_JMP);
                    data_e = (bus.opcode == OP_STO);
                end
                PH_STORE: begin
                    rd     = alu_instr;
                    ld_ac  = alu_instr;
                    ld_pc  = (bus.opcode == OP_JMP);
                    wr     = (bus.opcode == OP_STO);
                    data_e = (bus.opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign bus.sel     = sel;
    assign bus.rd      = rd;
    assign bus.ld_ir   = ld_ir;
    assign bus.inc_pc  = inc_pc;
    assign bus.ld_pc   = ld_pc;
    assign bus.ld_ac   = ld_ac;
    assign bus.acc_src = acc_src;
    assign bus.wr      = wr;
    assign bus.data_e  = data_e;
    assign bus.alu_op  = alu_op;
    assign bus.halt    = halt;
    assign bus.phase   = phase_q;

endmodule

// File: tb/tb_risc_ctrl.sv
// Directed bench for risc_ctrl: walks each instruction class through its
// eight phases against hand-written strobe tables, then exercises HLT and
// mid-instruction reset.
module tb_risc_ctrl;
    import risc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    risc_ctrl_if ifc ();

    risc_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Strobe word: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    function automatic logic [8:0] strobes();
        return {ifc.sel, ifc.rd, ifc.ld_ir, ifc.inc_pc, ifc.ld_pc,
                ifc.ld_ac, ifc.wr, ifc.data_e, ifc.halt};
    endfunction

    // Phases 0-3 are common fetch; the caller gives phases 4..7
    function automatic logic [7:0][8:0] instr_words(input logic [8:0] p4, p5, p6, p7);
        return {p7, p6, p5, p4, 9'h1C0, 9'h1C0, 9'h180, 9'h100};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction and check the first n phases; returns at the
    // negedge where the phase counter should equal n (mod 8)
    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input logic [7:0][8:0] exp, input logic [2:0] exp_alu,
                             input int n);
        ifc.opcode = op;
        ifc.zero   = z;
        for (int p = 0; p < n; p++) begin
            #1;
            check($sformatf("%s phase%0d phase", name, p), 16'(ifc.phase), 16'(p));
            check($sformatf("%s phase%0d strobes", name, p), 16'(strobes()), 16'(exp[p]));
            check($sformatf("%s phase%0d alu_op", name, p), 16'(ifc.alu_op), 16'(exp_alu));
            if (p == 7)
                check($sformatf("%s phase7 acc_src", name), 16'(ifc.acc_src),
                      16'(op == OP_LDA));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0][8:0] w_alu, w_sto, w_skz1, w_skz0, w_jmp, w_hlt;
        w_alu  = instr_words(9'h020, 9'h080, 9'h080, 9'h088);
        w_sto  = instr_words(9'h020, 9'h000, 9'h002, 9'h006);
        w_skz1 = instr_words(9'h020, 9'h000, 9'h020, 9'h000);
        w_skz0 = instr_words(9'h020, 9'h000, 9'h000, 9'h000);
        w_jmp  = instr_words(9'h020, 9'h000, 9'h010, 9'h010);
        w_hlt  = instr_words(9'h000, 9'h000, 9'h000, 9'h000);

        ifc.opcode = OP_ADD;
        ifc.zero   = 1'b0;

        // Values while reset is held
        #1;
        check("reset phase",   16'(ifc.phase),  16'd0);
        check("reset strobes", 16'(strobes()),  16'h100);
        check("reset alu_op",  16'(ifc.alu_op), 16'(3'b000));
        @(negedge clk);
        rst = 1'b0;

        // Main instruction classes, 8 cycles each, back to back
        run_instr("ADD",   OP_ADD, 1'b0, w_alu,  3'b000, 8);
        run_instr("ADDz",  OP_ADD, 1'b1, w_alu,  3'b000, 8);
        run_instr("AND",   OP_AND, 1'b0, w_alu,  3'b010, 8);
        run_instr("XOR",   OP_XOR, 1'b0, w_alu,  3'b100, 8);
        run_instr("LDA",   OP_LDA, 1'b0, w_alu,  3'b000, 8);
        run_instr("STO",   OP_STO, 1'b1, w_sto,  3'b000, 8);
        run_instr("SKZ1",  OP_SKZ, 1'b1, w_skz1, 3'b000, 8);
        run_instr("SKZ0",  OP_SKZ, 1'b0, w_skz0, 3'b000, 8);
        run_instr("JMP",   OP_JMP, 1'b0, w_jmp,  3'b000, 8);

        // zero only matters in phase 6: raise it in phase 5, drop before 6
        ifc.opcode = OP_SKZ;
        run_instr("SKZx",  OP_SKZ, 1'b1, w_skz0, 3'b000, 6);
        ifc.zero = 1'b0;
        #1;
        check("SKZx phase6 strobes", 16'(strobes()), 16'h000);
        @(negedge clk);
        ifc.zero = 1'b1;
        #1;
        check("SKZx phase7 strobes", 16'(strobes()), 16'h000);
        @(negedge clk);

        // Reset in the middle of an ADD, at phase 6
        run_instr("ADDr", OP_ADD, 1'b0, w_alu, 3'b000, 6);
        #2 rst = 1'b1;
        #1;
        check("midreset phase",   16'(ifc.phase), 16'd0);
        check("midreset strobes", 16'(strobes()), 16'h100);
        @(negedge clk);
        rst = 1'b0;

        // HLT: checks phases 0..4, then parks in phase 4 halted
        run_instr("HLT", OP_HLT, 1'b0, w_hlt, 3'b000, 5);
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("halted%0d phase", i),   16'(ifc.phase), 16'd4);
            check($sformatf("halted%0d strobes", i), 16'(strobes()), 16'h001);
            @(negedge clk);
        end
        // Opcode changes while halted have no effect
        ifc.opcode = OP_JMP;
        ifc.zero   = 1'b1;
        @(negedge clk);
        #1;
        check("halted jmp strobes", 16'(strobes()), 16'h001);
        check("halted jmp phase",   16'(ifc.phase), 16'd4);

        // Asynchronous reset leaves the halted state immediately
        #2 rst = 1'b1;
        #1;
        check("halt reset phase",   16'(ifc.phase), 16'd0);
        check("halt reset strobes", 16'(strobes()), 16'h100);
        @(negedge clk);
        rst = 1'b0;

        // Normal operation resumes after reset
        run_instr("LDA2", OP_LDA, 1'b0, w_alu, 3'b000, 8);
        #1;
        check("wrap phase", 16'(ifc.phase), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
